// File: rtl/operand_fetch_stage_pkg.sv
// Shared ISA definitions for the decode/register-read stage: opcodes,
// instruction field positions and the status register index.
package operand_fetch_stage_pkg;

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_J     = 5'b00001,
    OP_BNE   = 5'b00010,
    OP_JAL   = 5'b00011,
    OP_JR    = 5'b00100,
    OP_BLT   = 5'b00110,
    OP_SW    = 5'b00111,
    OP_LW    = 5'b01000,
    OP_SETX  = 5'b10101,
    OP_BEX   = 5'b10110
  } opcode_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;

  localparam int STATUS_REG_IDX = 30;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand bypass mux: r0 reads as zero, then the M-stage pending write,
// then the W-stage write landing this edge, else the register file value.
module operand_bypass #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] addr,
  input  logic [WIDTH-1:0] rfData,
  input  logic             mWen,
  input  logic [RADDR-1:0] mRd,
  input  logic [WIDTH-1:0] mData,
  input  logic             wWen,
  input  logic [RADDR-1:0] wRd,
  input  logic [WIDTH-1:0] wData,
  output logic [WIDTH-1:0] operand
);

  // Youngest matching producer wins; r0 is hard-wired to zero.
  always_comb begin
    operand = rfData;
    if (addr == '0) begin
      operand = '0;
    end else if (mWen && (mRd == addr)) begin
      operand = mData;
    end else if (wWen && (wRd == addr)) begin
      operand = wData;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/register-read stage: picks source registers from the fetched
// instruction, bypasses the read data, detects load-use hazards and loads
// the D/X pipeline register. Also counts load-use stall cycles.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADDR      = 5,
  parameter int STATUS_REG = STATUS_REG_IDX,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             f_valid,
  input  logic [WIDTH-1:0] f_insn,
  input  logic [WIDTH-1:0] f_pc,
  input  logic             flush,
  input  logic             x_stall,
  output logic             stall_out,
  output logic [RADDR-1:0] ctrl_readRegA,
  output logic [RADDR-1:0] ctrl_readRegB,
  input  logic [WIDTH-1:0] data_readRegA,
  input  logic [WIDTH-1:0] data_readRegB,
  input  logic             m_wen,
  input  logic [RADDR-1:0] m_rd,
  input  logic [WIDTH-1:0] m_data,
  input  logic             w_wen,
  input  logic [RADDR-1:0] w_rd,
  input  logic [WIDTH-1:0] w_data,
  output logic             dx_valid,
  output logic [WIDTH-1:0] dx_insn,
  output logic [WIDTH-1:0] dx_pc,
  output logic [WIDTH-1:0] dx_opA,
  output logic [WIDTH-1:0] dx_opB,
  output logic [CNT_W-1:0] stall_count
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  opcode_e          fOpc;
  logic [RADDR-1:0] fRd, fRs, fRt;
  logic [RADDR-1:0] srcA, srcB;
  logic             usesA, usesB;
  logic [WIDTH-1:0] opA_p0, opB_p0;
  logic             loadUse;

  logic             vld_p1;
  logic [WIDTH-1:0] insn_p1, pc_p1, opA_p1, opB_p1;
  logic [CNT_W-1:0] stallCnt;

  opcode_e          dxOpc;
  logic [RADDR-1:0] dxRd;

  assign fOpc  = opcode_e'(f_insn[OPC_MSB:OPC_LSB]);
  assign fRd   = f_insn[RD_MSB:RD_LSB];
  assign fRs   = f_insn[RS_MSB:RS_LSB];
  assign fRt   = f_insn[RT_MSB:RT_LSB];
  assign dxOpc = opcode_e'(insn_p1[OPC_MSB:OPC_LSB]);
  assign dxRd  = insn_p1[RD_MSB:RD_LSB];

  // Source register selection and which sources the opcode really reads.
  always_comb begin
    srcA  = fRs;
    usesA = 1'b1;
    srcB  = '0;
    usesB = 1'b0;
    case (fOpc)
      OP_BEX:                  srcA  = RADDR'(STATUS_REG);
      OP_J, OP_JAL, OP_SETX:   usesA = 1'b0;
      default:                 ;
    endcase
    case (fOpc)
      OP_RTYPE: begin
        srcB  = fRt;
        usesB = 1'b1;
      end
      OP_SW, OP_BNE, OP_BLT, OP_JR: begin
        srcB  = fRd;
        usesB = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_readRegA = srcA;
  assign ctrl_readRegB = srcB;

  operand_bypass #(.WIDTH(WIDTH), .RADDR(RADDR)) bypassA (
    .addr    (srcA),
    .rfData  (data_readRegA),
    .mWen    (m_wen),
    .mRd     (m_rd),
    .mData   (m_data),
    .wWen    (w_wen),
    .wRd     (w_rd),
    .wData   (w_data),
    .operand (opA_p0)
  );

  operand_bypass #(.WIDTH(WIDTH), .RADDR(RADDR)) bypassB (
    .addr    (srcB),
    .rfData  (data_readRegB),
    .mWen    (m_wen),
    .mRd     (m_rd),
    .mData   (m_data),
    .wWen    (w_wen),
    .wRd     (w_rd),
    .wData   (w_data),
    .operand (opB_p0)
  );

  // A load in D/X cannot forward in time to a dependent instruction in D.
  always_comb begin
    loadUse = vld_p1 && (dxOpc == OP_LW) && (dxRd != '0) && f_valid &&
              ((usesA && (srcA == dxRd)) || (usesB && (srcB == dxRd)));
  end

  assign stall_out = !ctrl_reset && !flush && (x_stall || loadUse);

  // ---- D/X pipeline register (stage p1) ----
  // Priority: reset, flush, execute hold, load-use bubble, normal capture.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      vld_p1   <= 1'b0;
      insn_p1  <= '0;
      pc_p1    <= '0;
      opA_p1   <= '0;
      opB_p1   <= '0;
      stallCnt <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      insn_p1 <= '0;
      pc_p1   <= '0;
      opA_p1  <= '0;
      opB_p1  <= '0;
    end else if (x_stall) begin
      vld_p1  <= vld_p1;
    end else if (loadUse) begin
      vld_p1   <= 1'b0;
      insn_p1  <= '0;
      pc_p1    <= '0;
      opA_p1   <= '0;
      opB_p1   <= '0;
      stallCnt <= satInc(stallCnt);
    end else begin
      vld_p1  <= f_valid;
      insn_p1 <= f_insn;
      pc_p1   <= f_pc;
      opA_p1  <= opA_p0;
      opB_p1  <= opB_p0;
    end
  end

  assign dx_valid    = vld_p1;
  assign dx_insn     = insn_p1;
  assign dx_pc       = pc_p1;
  assign dx_opA      = opA_p1;
  assign dx_opB      = opB_p1;
  assign stall_count = stallCnt;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register file.
module tb_operand_fetch_stage;

  localparam int TB_CNT_W = 4;  // narrow counter so saturation is reachable quickly
  localparam logic [4:0] RT  = 5'b00000;
  localparam logic [4:0] SW  = 5'b00111;
  localparam logic [4:0] LW  = 5'b01000;
  localparam logic [4:0] BEX = 5'b10110;

  logic                clock = 1'b0;
  logic                ctrl_reset, f_valid, flush, x_stall;
  logic [31:0]         f_insn, f_pc;
  logic                stall_out;
  logic [4:0]          ctrl_readRegA, ctrl_readRegB;
  logic [31:0]         data_readRegA, data_readRegB;
  logic                m_wen, w_wen;
  logic [4:0]          m_rd, w_rd;
  logic [31:0]         m_data, w_data;
  logic                dx_valid;
  logic [31:0]         dx_insn, dx_pc, dx_opA, dx_opB;
  logic [TB_CNT_W-1:0] stall_count;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  always #5 clock = ~clock;

  operand_fetch_stage #(.CNT_W(TB_CNT_W)) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .f_valid       (f_valid),
    .f_insn        (f_insn),
    .f_pc          (f_pc),
    .flush         (flush),
    .x_stall       (x_stall),
    .stall_out     (stall_out),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .m_wen         (m_wen),
    .m_rd          (m_rd),
    .m_data        (m_data),
    .w_wen         (w_wen),
    .w_rd          (w_rd),
    .w_data        (w_data),
    .dx_valid      (dx_valid),
    .dx_insn       (dx_insn),
    .dx_pc         (dx_pc),
    .dx_opA        (dx_opA),
    .dx_opB        (dx_opB),
    .stall_count   (stall_count)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] insn, input logic [31:0] pc);
    f_valid = 1'b1;
    f_insn  = insn;
    f_pc    = pc;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    ctrl_reset = 1'b1; f_valid = 1'b0; f_insn = '0; f_pc = '0;
    flush = 1'b0; x_stall = 1'b1;
    m_wen = 1'b0; m_rd = '0; m_data = '0;
    w_wen = 1'b0; w_rd = '0; w_data = '0;
    step();
    step();
    checkVal("rst_stall_out", 32'(stall_out), 32'd0);
    checkVal("rst_dx_valid", 32'(dx_valid), 32'd0);
    checkVal("rst_dx_insn", dx_insn, 32'd0);
    checkVal("rst_count", 32'(stall_count), 32'd0);
    ctrl_reset = 1'b0; x_stall = 1'b0;

    // add r3,r1,r2 from the register file
    present(mk(RT, 5'd3, 5'd1, 5'd2), 32'h100);
    checkVal("add_readA", 32'(ctrl_readRegA), 32'd1);
    checkVal("add_readB", 32'(ctrl_readRegB), 32'd2);
    step();
    checkVal("add_opA", dx_opA, 32'd5);
    checkVal("add_opB", dx_opB, 32'd7);
    checkVal("add_valid", 32'(dx_valid), 32'd1);
    checkVal("add_pc", dx_pc, 32'h100);
    checkVal("add_insn", dx_insn, mk(RT, 5'd3, 5'd1, 5'd2));

    // forwarding priority
    m_wen = 1'b1; m_rd = 5'd1; m_data = 32'd9;
    w_wen = 1'b1; w_rd = 5'd1; w_data = 32'd4;
    present(mk(RT, 5'd3, 5'd1, 5'd1), 32'h104);
    step();
    checkVal("fwdM_opA", dx_opA, 32'd9);
    checkVal("fwdM_opB", dx_opB, 32'd9);
    m_wen = 1'b0;
    step();
    checkVal("fwdW_opA", dx_opA, 32'd4);
    checkVal("fwdW_opB", dx_opB, 32'd4);
    m_wen = 1'b1; m_rd = 5'd0; w_rd = 5'd0;
    present(mk(RT, 5'd3, 5'd0, 5'd0), 32'h108);
    step();
    checkVal("r0_opA", dx_opA, 32'd0);
    checkVal("r0_opB", dx_opB, 32'd0);
    m_wen = 1'b0; w_wen = 1'b0;

    // source selection for sw and bex
    present(mk(SW, 5'd6, 5'd7, 5'd0), 32'h10C);
    checkVal("sw_readA", 32'(ctrl_readRegA), 32'd7);
    checkVal("sw_readB", 32'(ctrl_readRegB), 32'd6);
    present(mk(BEX, 5'd0, 5'd0, 5'd0), 32'h110);
    checkVal("bex_readA", 32'(ctrl_readRegA), 32'd30);
    checkVal("bex_nostall", 32'(stall_out), 32'd0);

    // load-use: lw r4 then add r5,r4,r2
    present(mk(LW, 5'd4, 5'd1, 5'd0), 32'h200);
    step();
    present(mk(RT, 5'd5, 5'd4, 5'd2), 32'h204);
    checkVal("lu_stall_out", 32'(stall_out), 32'd1);
    step();
    checkVal("lu_bubble", 32'(dx_valid), 32'd0);
    checkVal("lu_count", 32'(stall_count), 32'd1);
    m_wen = 1'b1; m_rd = 5'd4; m_data = 32'h55;
    #1;
    checkVal("lu_release", 32'(stall_out), 32'd0);
    step();
    checkVal("lu_valid", 32'(dx_valid), 32'd1);
    checkVal("lu_opA", dx_opA, 32'h55);
    checkVal("lu_opB", dx_opB, 32'd7);
    checkVal("lu_pc", dx_pc, 32'h204);
    m_wen = 1'b0;

    // execute hold for three cycles, then flush over the hold
    present(mk(RT, 5'd3, 5'd1, 5'd2), 32'h300);
    x_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkVal("xs_stall_out", 32'(stall_out), 32'd1);
      step();
      checkVal("xs_hold_insn", dx_insn, mk(RT, 5'd5, 5'd4, 5'd2));
      checkVal("xs_hold_opA", dx_opA, 32'h55);
      checkVal("xs_count", 32'(stall_count), 32'd1);
    end
    flush = 1'b1;
    #1;
    checkVal("fl_stall_out", 32'(stall_out), 32'd0);
    step();
    checkVal("fl_valid", 32'(dx_valid), 32'd0);
    checkVal("fl_insn", dx_insn, 32'd0);
    flush = 1'b0; x_stall = 1'b0;

    // bubble from fetch
    f_valid = 1'b0;
    step();
    checkVal("bub_valid", 32'(dx_valid), 32'd0);
    checkVal("bub_count", 32'(stall_count), 32'd1);

    // reset during a load-use stall
    present(mk(LW, 5'd4, 5'd1, 5'd0), 32'h400);
    step();
    present(mk(RT, 5'd5, 5'd4, 5'd2), 32'h404);
    checkVal("rlu_stall", 32'(stall_out), 32'd1);
    ctrl_reset = 1'b1;
    #1;
    checkVal("rlu_stall_rst", 32'(stall_out), 32'd0);
    step();
    checkVal("rlu_valid", 32'(dx_valid), 32'd0);
    checkVal("rlu_count", 32'(stall_count), 32'd0);
    ctrl_reset = 1'b0;

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      present(mk(LW, 5'd4, 5'd1, 5'd0), 32'h500);
      step();
      present(mk(RT, 5'd5, 5'd4, 5'd2), 32'h504);
      step();
      if (i == 12) checkVal("sat_13", 32'(stall_count), 32'd13);
      if (i == 14) checkVal("sat_max", 32'(stall_count), 32'hF);
    end
    checkVal("sat_hold", 32'(stall_count), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
